// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-cache block-memory arbiter.
// Optional round-robin arbitration is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W  = 28;
    localparam int unsigned MEM_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // Serve state that corresponds to a given grant.
    function automatic arb_state_e serve_state(input grant_e g);
        return (g == GRANT_D) ? SERVE_D : SERVE_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_grant_select.sv
// Combinational grant pick between the icache and dcache requests.
// With MEM_ARB_ROUND_ROBIN_EN defined, contested requests go to the port not served last.
module mem_arbiter_grant_select
    import mem_arbiter_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  grant_e last_grant_i,
`endif
    output logic   req_any_o,
    output grant_e grant_o
);

    always_comb begin
        req_any_o = i_req_i | d_req_i;
        grant_o   = d_req_i ? GRANT_D : GRANT_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_req_i && d_req_i) begin
            grant_o = (last_grant_i == GRANT_I) ? GRANT_D : GRANT_I;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block memory between icache and dcache using the read/write/busywait protocol.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is dcache-over-icache priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned BLOCK_W = MEM_BLOCK_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [BLOCK_W-1:0] i_readdata,
    output logic               i_busywait,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [BLOCK_W-1:0] d_writedata,
    output logic [BLOCK_W-1:0] d_readdata,
    output logic               d_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait
);

    arb_state_e state_q;
    logic       i_req;
    logic       d_req;
    logic       req_any;
    grant_e     grant;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_e     last_grant_q;
`endif

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    mem_arbiter_grant_select u_grant_select (
        .i_req_i      (i_req),
        .d_req_i      (d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant_i (last_grant_q),
`endif
        .req_any_o    (req_any),
        .grant_o      (grant)
    );

    // Arbitration FSM; the state encodes the registered grant.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= GRANT_I;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        state_q      <= serve_state(grant);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant_q <= grant;
`endif
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (!mem_busywait) begin
                        state_q <= RELEASE;
                    end
                end
                RELEASE: state_q <= IDLE;
            endcase
        end
    end

    // Forward the granted port to memory; RELEASE keeps memory quiet while the cache drops its request.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        i_busywait    = i_req;
        d_busywait    = d_req;
        case (state_q)
            SERVE_I: begin
                mem_read    = i_read;
                mem_address = i_address;
                i_busywait  = mem_busywait;
            end
            SERVE_D: begin
                mem_read      = d_read;
                mem_write     = d_write;
                mem_address   = d_address;
                mem_writedata = d_writedata;
                d_busywait    = mem_busywait;
            end
            default: ;
        endcase
    end

    assign i_readdata = mem_readdata;
    assign d_readdata = mem_readdata;

    // A granted requester must hold its request until the memory completes.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            assert (!(state_q == SERVE_I && !i_req));
            assert (!(state_q == SERVE_D && !d_req));
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 5-busy + 1-done cycle memory model.
module tb_mem_arbiter;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         i_read;
    logic [27:0]  i_address;
    logic [127:0] i_readdata;
    logic         i_busywait;
    logic         d_read;
    logic         d_write;
    logic [27:0]  d_address;
    logic [127:0] d_writedata;
    logic [127:0] d_readdata;
    logic         d_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_busywait(d_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 CLK = ~CLK;

    // Memory model: busy for 5 cycles of a request, done on the 6th.
    int           mcnt = 0;
    logic [27:0]  log_addr[$];
    logic         log_wr[$];
    logic [127:0] log_data[$];

    function automatic logic [127:0] blk(input logic [27:0] a);
        return {4{4'hA, a}};
    endfunction

    assign mem_busywait = (mem_read | mem_write) && (mcnt != 5);
    assign mem_readdata = blk(mem_address);

    always @(posedge CLK) begin
        if (RESET) begin
            mcnt <= 0;
        end else if (mem_read | mem_write) begin
            if (mcnt == 5) begin
                mcnt <= 0;
                log_addr.push_back(mem_address);
                log_wr.push_back(mem_write);
                log_data.push_back(mem_writedata);
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read got %0b want 0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got %0b want 0", mem_write); end
        checks++; if (i_busywait !== 1'b0) begin errors++; $display("FAIL rst_i_busy got %0b want 0", i_busywait); end
        checks++; if (d_busywait !== 1'b0) begin errors++; $display("FAIL rst_d_busy got %0b want 0", d_busywait); end
        i_read = 1'b1;
        #1;
        checks++; if (i_busywait !== 1'b1) begin errors++; $display("FAIL idle_i_busy_follows got %0b want 1", i_busywait); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL idle_no_mem_read got %0b want 0", mem_read); end
        i_read = 1'b0;
        d_write = 1'b1;
        #1;
        checks++; if (d_busywait !== 1'b1) begin errors++; $display("FAIL idle_d_busy_follows got %0b want 1", d_busywait); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL idle_no_mem_write got %0b want 0", mem_write); end
        d_write = 1'b0;
        step();
    endtask

    task automatic test_icache_read();
        int base = log_addr.size();
        i_read = 1'b1;
        i_address = 28'h10;
        #1;
        checks++; if (i_busywait !== 1'b1) begin errors++; $display("FAIL ic_c0_busy got %0b want 1", i_busywait); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL ic_c0_mem_read got %0b want 0", mem_read); end
        for (int k = 1; k <= 6; k++) begin
            step();
            #1;
            checks++;
            if ({mem_read, mem_write, mem_address} !== {1'b1, 1'b0, 28'h10}) begin
                errors++; $display("FAIL ic_fwd cyc %0d got rd=%0b wr=%0b a=%0h want rd=1 wr=0 a=10", k, mem_read, mem_write, mem_address);
            end
            checks++;
            if (i_busywait !== ((k < 6) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL ic_busy cyc %0d got %0b want %0b", k, i_busywait, (k < 6));
            end
            checks++; if (d_busywait !== 1'b0) begin errors++; $display("FAIL ic_d_busy cyc %0d got %0b want 0", k, d_busywait); end
            if (k == 6) begin
                checks++;
                if (i_readdata !== blk(28'h10)) begin errors++; $display("FAIL ic_readdata got %0h want %0h", i_readdata, blk(28'h10)); end
            end
        end
        step();
        i_read = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL ic_release_mem_read got %0b want 0", mem_read); end
        checks++; if (i_busywait !== 1'b0) begin errors++; $display("FAIL ic_release_busy got %0b want 0", i_busywait); end
        step();
        checks++;
        if (log_addr.size() !== base + 1) begin
            errors++; $display("FAIL ic_txn_count got %0d want %0d", log_addr.size() - base, 1);
        end else begin
            checks++;
            if ({log_wr[base], log_addr[base]} !== {1'b0, 28'h10}) begin
                errors++; $display("FAIL ic_txn got wr=%0b a=%0h want wr=0 a=10", log_wr[base], log_addr[base]);
            end
        end
    endtask

    task automatic test_dcache_write();
        int base = log_addr.size();
        logic [127:0] wdata = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        d_write = 1'b1;
        d_address = 28'h20;
        d_writedata = wdata;
        #1;
        checks++; if (d_busywait !== 1'b1) begin errors++; $display("FAIL dw_c0_busy got %0b want 1", d_busywait); end
        for (int k = 1; k <= 6; k++) begin
            step();
            #1;
            checks++;
            if ({mem_read, mem_write, mem_address} !== {1'b0, 1'b1, 28'h20}) begin
                errors++; $display("FAIL dw_fwd cyc %0d got rd=%0b wr=%0b a=%0h want rd=0 wr=1 a=20", k, mem_read, mem_write, mem_address);
            end
            checks++; if (mem_writedata !== wdata) begin errors++; $display("FAIL dw_wdata cyc %0d got %0h want %0h", k, mem_writedata, wdata); end
            checks++;
            if (d_busywait !== ((k < 6) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL dw_busy cyc %0d got %0b want %0b", k, d_busywait, (k < 6));
            end
            checks++; if (i_busywait !== 1'b0) begin errors++; $display("FAIL dw_i_busy cyc %0d got %0b want 0", k, i_busywait); end
        end
        step();
        d_write = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL dw_release_mem_write got %0b want 0", mem_write); end
        step();
        checks++;
        if (log_addr.size() !== base + 1) begin
            errors++; $display("FAIL dw_txn_count got %0d want %0d", log_addr.size() - base, 1);
        end else begin
            checks++;
            if ({log_wr[base], log_addr[base], log_data[base]} !== {1'b1, 28'h20, wdata}) begin
                errors++; $display("FAIL dw_txn got wr=%0b a=%0h d=%0h want wr=1 a=20 d=%0h", log_wr[base], log_addr[base], log_data[base], wdata);
            end
        end
    endtask

    // Both caches request together; the first-served port re-requests right after its RELEASE.
    task automatic test_priority();
        logic        exp_d[3];
        logic [27:0] exp_a[3];
        int          base;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_d = '{1'b1, 1'b0, 1'b1};
        exp_a = '{28'h30, 28'h10, 28'h34};
`else
        exp_d = '{1'b1, 1'b1, 1'b0};
        exp_a = '{28'h30, 28'h34, 28'h10};
`endif
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        base = log_addr.size();
        i_read = 1'b1;
        i_address = 28'h10;
        d_read = 1'b1;
        d_address = 28'h30;
        #1;
        checks++;
        if ({i_busywait, d_busywait} !== 2'b11) begin errors++; $display("FAIL pr_c0_busy got %02b want 11", {i_busywait, d_busywait}); end
        for (int s = 0; s < 3; s++) begin
            int   n = 0;
            logic done = 1'b0;
            while (!done && n < 20) begin
                step();
                #1;
                n++;
                checks++;
                if ({mem_read, mem_address} !== {1'b1, exp_a[s]}) begin
                    errors++; $display("FAIL pr_fwd svc %0d cyc %0d got rd=%0b a=%0h want rd=1 a=%0h", s, n, mem_read, mem_address, exp_a[s]);
                end
                checks++;
                if (exp_d[s] ? (i_busywait !== i_read) : (d_busywait !== d_read)) begin
                    errors++; $display("FAIL pr_other_busy svc %0d cyc %0d got i=%0b d=%0b", s, n, i_busywait, d_busywait);
                end
                done = exp_d[s] ? !d_busywait : !i_busywait;
            end
            checks++; if (n !== 6) begin errors++; $display("FAIL pr_serve_len svc %0d got %0d want 6", s, n); end
            checks++;
            if ((exp_d[s] ? d_readdata : i_readdata) !== blk(exp_a[s])) begin
                errors++; $display("FAIL pr_readdata svc %0d got %0h want %0h", s, exp_d[s] ? d_readdata : i_readdata, blk(exp_a[s]));
            end
            step();
            if (exp_d[s]) d_read = 1'b0; else i_read = 1'b0;
            #1;
            checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL pr_release svc %0d got %0b want 0", s, mem_read); end
            step();
            if (s == 0) begin
                d_read = 1'b1;
                d_address = 28'h34;
            end
            #1;
            checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL pr_idle_gap svc %0d got %0b want 0", s, mem_read); end
        end
        checks++;
        if (log_addr.size() !== base + 3) begin
            errors++; $display("FAIL pr_txn_count got %0d want 3", log_addr.size() - base);
        end else begin
            for (int s = 0; s < 3; s++) begin
                checks++;
                if (log_addr[base + s] !== exp_a[s]) begin
                    errors++; $display("FAIL pr_order svc %0d got %0h want %0h", s, log_addr[base + s], exp_a[s]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_serve();
        int base = log_addr.size();
        d_read = 1'b1;
        d_address = 28'h40;
        step();
        step();
        step();
        #1;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rs_serving got %0b want 1", mem_read); end
        RESET = 1'b1;
        d_read = 1'b0;
        step();
        RESET = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, d_busywait} !== 3'b000) begin
            errors++; $display("FAIL rs_after_reset got rd=%0b wr=%0b busy=%0b want 000", mem_read, mem_write, d_busywait);
        end
        checks++; if (log_addr.size() !== base) begin errors++; $display("FAIL rs_abandoned got %0d txns want 0", log_addr.size() - base); end
        step();
        d_read = 1'b1;
        #1;
        checks++;
        if ({d_busywait, mem_read} !== 2'b10) begin errors++; $display("FAIL rs_regrant_idle got busy=%0b rd=%0b want busy=1 rd=0", d_busywait, mem_read); end
        for (int k = 1; k <= 6; k++) begin
            step();
            #1;
            checks++;
            if ({mem_read, mem_address, d_busywait} !== {1'b1, 28'h40, (k < 6) ? 1'b1 : 1'b0}) begin
                errors++; $display("FAIL rs_reserve cyc %0d got rd=%0b a=%0h busy=%0b", k, mem_read, mem_address, d_busywait);
            end
        end
        step();
        d_read = 1'b0;
        step();
        checks++; if (log_addr.size() !== base + 1) begin errors++; $display("FAIL rs_txn_count got %0d want 1", log_addr.size() - base); end
    endtask

    task automatic test_back_to_back();
        int          base = log_addr.size();
        logic [27:0] addr[2];
        addr = '{28'h50, 28'h54};
        for (int t = 0; t < 2; t++) begin
            int   n = 0;
            logic done = 1'b0;
            d_read = 1'b1;
            d_address = addr[t];
            #1;
            checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap txn %0d got %0b want 0", t, mem_read); end
            while (!done && n < 20) begin
                step();
                #1;
                n++;
                checks++;
                if ({mem_read, mem_address} !== {1'b1, addr[t]}) begin
                    errors++; $display("FAIL b2b_fwd txn %0d cyc %0d got rd=%0b a=%0h want rd=1 a=%0h", t, n, mem_read, mem_address, addr[t]);
                end
                done = !d_busywait;
            end
            checks++; if (n !== 6) begin errors++; $display("FAIL b2b_serve_len txn %0d got %0d want 6", t, n); end
            step();
            d_read = 1'b0;
            #1;
            checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL b2b_release txn %0d got %0b want 0", t, mem_read); end
            step();
        end
        checks++;
        if (log_addr.size() !== base + 2) begin
            errors++; $display("FAIL b2b_txn_count got %0d want 2", log_addr.size() - base);
        end else begin
            checks++;
            if ({log_addr[base], log_addr[base + 1]} !== {addr[0], addr[1]}) begin
                errors++; $display("FAIL b2b_order got %0h,%0h want %0h,%0h", log_addr[base], log_addr[base + 1], addr[0], addr[1]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1;
        i_read = 1'b0;
        i_address = '0;
        d_read = 1'b0;
        d_write = 1'b0;
        d_address = '0;
        d_writedata = '0;
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_priority();
        test_reset_mid_serve();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
